// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM state encodings,
// instruction width and the NOP word loaded into the instruction register.
package seq_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned STATE_W = 3;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP = 32'h00000013;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter register, next-PC adder and alignment check.
// Ports:
//   clk, rst   - clock, async active-high reset (pc <= RESET_PC)
//   update     - load next_pc into pc on this edge
//   taken      - select pc+offset instead of pc+4
//   offset     - branch offset, already truncated to PC_W
//   pc         - current PC
//   misaligned - next PC is not 4-byte aligned
module pc_unit #(
    parameter int unsigned      PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            update,
    input  logic            taken,
    input  logic [PC_W-1:0] offset,
    output logic [PC_W-1:0] pc,
    output logic            misaligned
);

    logic [PC_W-1:0] next_pc;

    // Addition wraps modulo 2^PC_W by construction.
    assign next_pc    = pc + (taken ? offset : PC_W'(4));
    assign misaligned = |next_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (update) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/seq_core_sequencer.sv
// Multi-cycle control and PC block for the sequential core. Steps each
// instruction through FETCH, DECODE, EXEC, optional MEM and WB, using
// req/ready handshakes to both memories, and halts on faults.
// Ports:
//   clk, rst                     - clock, async active-high reset
//   run                          - allow new instructions (sampled in IDLE/WB)
//   imem_req/addr/ready/rdata    - instruction fetch handshake
//   instr                        - instruction register to decode
//   illegal, branch, alu_zero,
//   imm, mem_read, mem_write,
//   reg_write                    - decode/execute controls, stable DECODE..WB
//   dmem_req/ready               - data memory handshake
//   rf_we                        - register-file write strobe (WB only)
//   pc, state, halted, retired   - status
module seq_core_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned      XLEN     = 64,
    parameter int unsigned      PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter int unsigned      CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    input  logic               illegal,
    input  logic               branch,
    input  logic               alu_zero,
    input  logic [XLEN-1:0]    imm,
    input  logic               mem_read,
    input  logic               mem_write,
    output logic               dmem_req,
    input  logic               dmem_ready,
    input  logic               reg_write,
    output logic               rf_we,
    output logic [PC_W-1:0]    pc,
    output logic [STATE_W-1:0] state,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    state_t state_q;
    state_t state_d;
    logic   misaligned;
    logic   retire;

    // Only the low PC_W bits of the immediate contribute to the branch target.
    generate
        if (XLEN > PC_W) begin : g_imm_hi
            logic unused_imm_hi;
            assign unused_imm_hi = ^imm[XLEN-1:PC_W];
        end
    endgenerate

    // An instruction retires only when its next PC is aligned.
    assign retire = (state_q == S_WB) && !misaligned;

    pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .update     (retire),
        .taken      (branch & alu_zero),
        .offset     (imm[PC_W-1:0]),
        .pc         (pc),
        .misaligned (misaligned)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ready inputs only matter in their own state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (imem_ready) state_d = S_DECODE;
            S_DECODE: state_d = illegal ? S_HALT : S_EXEC;
            S_EXEC:   state_d = (mem_read || mem_write) ? S_MEM : S_WB;
            S_MEM:    if (dmem_ready) state_d = S_WB;
            S_WB: begin
                if (misaligned) begin
                    state_d = S_HALT;
                end else if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Instruction register captures the fetched word on the FETCH exit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= NOP;
        end else if (state_q == S_FETCH && imem_ready) begin
            instr <= imem_rdata;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // Strobes decoded from the registered state.
    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc;
    assign dmem_req  = (state_q == S_MEM);
    assign rf_we     = (state_q == S_WB) && reg_write;
    assign halted    = (state_q == S_HALT);
    assign state     = state_q;

endmodule

// File: tb/tb_seq_core_sequencer.sv
module tb_seq_core_sequencer;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             run;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ready;
    logic [31:0]      imem_rdata;
    logic [31:0]      instr;
    logic             illegal;
    logic             branch;
    logic             alu_zero;
    logic [XLEN-1:0]  imm;
    logic             mem_read;
    logic             mem_write;
    logic             dmem_req;
    logic             dmem_ready;
    logic             reg_write;
    logic             rf_we;
    logic [PC_W-1:0]  pc;
    logic [2:0]       state;
    logic             halted;
    logic [CNT_W-1:0] retired;

    int tests = 0;
    int fails = 0;

    seq_core_sequencer #(
        .XLEN     (XLEN),
        .PC_W     (PC_W),
        .RESET_PC (32'h0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .illegal    (illegal),
        .branch     (branch),
        .alu_zero   (alu_zero),
        .imm        (imm),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .reg_write  (reg_write),
        .rf_we      (rf_we),
        .pc         (pc),
        .state      (state),
        .halted     (halted),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          iw;
        int          dw;
        logic        run;
        logic        illegal;
        logic        branch;
        logic        alu_zero;
        logic        mrd;
        logic        mwr;
        logic        rw;
        logic [63:0] imm;
        logic [31:0] rdata;
        logic [31:0] exp_trace;
        int          exp_cycles;
        int          exp_rfwe;
        logic [31:0] exp_pc;
        logic [3:0]  exp_ret;
        logic        exp_halted;
    } vec_t;

    function automatic vec_t mk(int iw, int dw, logic r, logic ill, logic br, logic az,
                                logic mrd, logic mwr, logic rw, logic [63:0] im,
                                logic [31:0] rd, logic [31:0] tr, int cyc, int nwe,
                                logic [31:0] epc, logic [3:0] eret, logic ehalt);
        vec_t v;
        v.iw = iw; v.dw = dw; v.run = r; v.illegal = ill; v.branch = br;
        v.alu_zero = az; v.mrd = mrd; v.mwr = mwr; v.rw = rw; v.imm = im;
        v.rdata = rd; v.exp_trace = tr; v.exp_cycles = cyc; v.exp_rfwe = nwe;
        v.exp_pc = epc; v.exp_ret = eret; v.exp_halted = ehalt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one instruction from FETCH (or IDLE) to its end, recording the
    // state trace as one nibble per cycle; caller is at a negedge.
    task automatic run_vec(input vec_t v, input string name);
        int          iw;
        int          dw;
        int          cycles;
        int          nwe;
        int          req_bad;
        logic [31:0] trace;
        logic        seen_wb;
        logic        done;
        logic [2:0]  s;
        iw = v.iw; dw = v.dw;
        run = v.run; illegal = v.illegal; branch = v.branch; alu_zero = v.alu_zero;
        mem_read = v.mrd; mem_write = v.mwr; reg_write = v.rw; imm = v.imm;
        imem_rdata = v.rdata;
        for (int k = 0; k < 5 && state == 3'd0; k++) @(negedge clk);
        cycles = 0; nwe = 0; req_bad = 0; trace = '0; seen_wb = 1'b0; done = 1'b0;
        while (!done && cycles < 40) begin
            s = state;
            if (s == 3'd0 || s == 3'd6 || seen_wb) begin
                done = 1'b1;
            end else begin
                cycles++;
                trace = {trace[27:0], 1'b0, s};
                if (s == 3'd5) seen_wb = 1'b1;
                if (rf_we) nwe++;
                // Readies are held high outside their own state to show they are ignored.
                if (s == 3'd1) begin
                    if (!imem_req || imem_addr !== pc || dmem_req) req_bad++;
                    imem_ready = (iw == 0);
                    if (iw > 0) iw--;
                end else begin
                    imem_ready = 1'b1;
                end
                if (s == 3'd4) begin
                    if (!dmem_req || imem_req) req_bad++;
                    dmem_ready = (dw == 0);
                    if (dw > 0) dw--;
                end else begin
                    dmem_ready = 1'b1;
                end
                @(negedge clk);
            end
        end
        chk({name, "_done"},    64'(done), 64'd1);
        chk({name, "_trace"},   64'(trace), 64'(v.exp_trace));
        chk({name, "_cycles"},  64'(cycles), 64'(v.exp_cycles));
        chk({name, "_rf_we"},   64'(nwe), 64'(v.exp_rfwe));
        chk({name, "_req"},     64'(req_bad), 64'd0);
        chk({name, "_pc"},      64'(pc), 64'(v.exp_pc));
        chk({name, "_retired"}, 64'(retired), 64'(v.exp_ret));
        chk({name, "_instr"},   64'(instr), 64'(v.rdata));
        chk({name, "_halted"},  64'(halted), 64'(v.exp_halted));
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_state"},   64'(state), 64'd0);
        chk({name, "_pc"},      64'(pc), 64'd0);
        chk({name, "_instr"},   64'(instr), 64'h13);
        chk({name, "_retired"}, 64'(retired), 64'd0);
        chk({name, "_strobes"}, 64'({imem_req, dmem_req, rf_we, halted}), 64'd0);
    endtask

    localparam logic [63:0] IMM_M8 = 64'hFFFF_FFFF_FFFF_FFF8;

    vec_t vt[15];

    initial begin
        int bad;
        int k;
        // addi, addi w/ 2 fetch waits, load w/ 3 data waits, store,
        // branches taken/not taken, run dropped mid-instruction, restart.
        vt[0] = mk(0,0,1,0,0,0,0,0,1, 64'd0, 32'h00100093, 32'h1235,     4,1, 32'h04, 4'd1, 0);
        vt[1] = mk(2,0,1,0,0,0,0,0,1, 64'd0, 32'h00208113, 32'h111235,   6,1, 32'h08, 4'd2, 0);
        vt[2] = mk(0,3,1,0,0,0,1,0,1, 64'd0, 32'h0000a183, 32'h12344445, 8,1, 32'h0C, 4'd3, 0);
        vt[3] = mk(0,0,1,0,0,0,0,1,0, 64'd0, 32'h0030a023, 32'h12345,    5,0, 32'h10, 4'd4, 0);
        vt[4] = mk(0,0,1,0,1,1,0,0,0, IMM_M8, 32'hfe000ce3, 32'h1235,    4,0, 32'h08, 4'd5, 0);
        vt[5] = mk(0,0,1,0,1,1,0,0,0, 64'd8, 32'h00000463, 32'h1235,     4,0, 32'h10, 4'd6, 0);
        vt[6] = mk(0,0,1,0,1,0,0,0,0, IMM_M8, 32'hfe000ce3, 32'h1235,    4,0, 32'h14, 4'd7, 0);
        vt[7] = mk(0,0,1,0,1,0,0,0,0, 64'd6, 32'h00000363, 32'h1235,     4,0, 32'h18, 4'd8, 0);
        vt[8] = mk(0,0,0,0,0,0,0,0,1, 64'd0, 32'h00400213, 32'h1235,     4,1, 32'h1C, 4'd9, 0);
        vt[9] = mk(1,0,1,0,0,0,0,0,1, 64'd0, 32'h00500293, 32'h11235,    5,1, 32'h20, 4'd10, 0);
        for (int i = 10; i < 15; i++)
            vt[i] = mk(0,0,1,0,0,0,0,0,1, 64'd0, 32'h00000093 | 32'(i << 20), 32'h1235, 4,1,
                       32'h20 + 32'(4 * (i - 9)), 4'(i + 1), 0);

        rst = 1'b1; run = 1'b0; imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0;
        illegal = 1'b0; branch = 1'b0; alu_zero = 1'b0; imm = '0;
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold", 64'(state), 64'd0);

        for (int i = 0; i < 15; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Reset in the middle of a stalled load after 15 retirements.
        run = 1'b1; mem_read = 1'b1; reg_write = 1'b1; branch = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b0;
        k = 0;
        while (state != 3'd4 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("rstmem_reach", 64'(state), 64'd4);
        @(negedge clk);
        chk("rstmem_dreq", 64'(dmem_req), 64'd1);
        chk("rstmem_ret15", 64'(retired), 64'd15);
        #1 rst = 1'b1;
        #1 chk_reset_vals("rstmem");
        @(negedge clk);
        mem_read = 1'b0;
        rst = 1'b0;

        // 16 instructions from reset: the 16th wraps the 4-bit counter.
        for (int i = 0; i < 16; i++)
            run_vec(mk(0,0,1,0,0,0,0,0,1, 64'd0, 32'h00100093 | 32'(i << 7), 32'h1235, 4,1,
                       32'(4 * (i + 1)), 4'(i + 1), 0), $sformatf("wrap%0d", i));

        // Taken branch to a misaligned target halts without retiring.
        run_vec(mk(0,0,1,0,1,1,0,0,0, 64'd6, 32'h00000363, 32'h1235, 4,0,
                   32'h40, 4'd0, 1), "misalign");
        bad = 0;
        imem_ready = 1'b1; dmem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (state != 3'd6 || imem_req || dmem_req || rf_we || pc != 32'h40) bad++;
            @(negedge clk);
        end
        chk("halt_sticky", 64'(bad), 64'd0);

        // Illegal opcode halts straight out of DECODE with no write.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(0,0,1,1,0,0,0,0,1, 64'd0, 32'hffffffff, 32'h12, 2,0,
                   32'h0, 4'd0, 1), "illegal");
        repeat (2) @(negedge clk);
        chk("illegal_stay", 64'({state, rf_we}), 64'({3'd6, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
